// File: rtl/bmp_gray_writer_pkg.sv
// Shared constants, FSM state type and row-padding helper for the BMP writer.
package bmp_pkg;

  localparam int unsigned HEADER_SIZE = 54;
  localparam int unsigned BMP_BPP     = 24;
  localparam int unsigned BMP_PPM     = 2835;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StFetch,
    StCapt,
    StPix,
    StPad
  } bmp_state_t;

  // Zero bytes needed to bring one row of 24-bit pixels up to a 4-byte multiple.
  function automatic int unsigned row_pad(input int unsigned width);
    return (4 - ((width * 3) % 4)) % 4;
  endfunction

endpackage

// File: rtl/bmp_gray_writer_if.sv
// Pixel-FIFO read side and byte-FIFO write side of the BMP writer.
interface bmp_gray_writer_if;

  logic       in_rd_en;
  logic [7:0] in_dout;
  logic       in_empty;
  logic       out_wr_en;
  logic [7:0] out_din;
  logic       out_full;

  // Writer side.
  modport master (
    output in_rd_en,
    input  in_dout,
    input  in_empty,
    output out_wr_en,
    output out_din,
    input  out_full
  );

  // FIFO side.
  modport slave (
    input  in_rd_en,
    output in_dout,
    output in_empty,
    input  out_wr_en,
    input  out_din,
    output out_full
  );

endinterface

// File: rtl/bmp_gray_writer_header_rom.sv
// Combinational 54-byte BMP header, selected by byte index.
module bmp_header_rom
  import bmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 720,
  parameter int unsigned HEIGHT = 720
) (
  input  logic [5:0] hidx_i,
  output logic [7:0] byte_o
);

  localparam int unsigned RowBytes = WIDTH * 3 + row_pad(WIDTH);
  localparam logic [31:0] ImgSize  = 32'(RowBytes * HEIGHT);
  localparam logic [31:0] FileSize = 32'(HEADER_SIZE) + ImgSize;
  localparam logic [31:0] DataOff  = 32'(HEADER_SIZE);
  localparam logic [31:0] DibSize  = 32'd40;
  localparam logic [31:0] Width32  = 32'(WIDTH);
  localparam logic [31:0] Height32 = 32'(HEIGHT);
  localparam logic [31:0] Ppm32    = 32'(BMP_PPM);
  // Bytes 26..29 pack planes (16 bit) and bpp (16 bit) into one little-endian word.
  localparam logic [31:0] PlaneBpp = {16'(BMP_BPP), 16'd1};

  logic [5:0]  off;
  logic [31:0] word;

  // After the 'BM' magic every field lives in a 4-byte group starting at byte 2.
  always_comb begin
    off  = hidx_i - 6'd2;
    word = 32'h0;
    case (off[5:2])
      4'd0:    word = FileSize;
      4'd2:    word = DataOff;
      4'd3:    word = DibSize;
      4'd4:    word = Width32;
      4'd5:    word = Height32;
      4'd6:    word = PlaneBpp;
      4'd8:    word = ImgSize;
      4'd9:    word = Ppm32;
      4'd10:   word = Ppm32;
      default: word = 32'h0;
    endcase
    byte_o = word[{off[1:0], 3'b000} +: 8];
    if (hidx_i == 6'd0) begin
      byte_o = 8'h42;
    end else if (hidx_i == 6'd1) begin
      byte_o = 8'h4D;
    end
  end

endmodule

// File: rtl/bmp_gray_writer.sv
// Streams one grayscale frame from a pixel FIFO as a 24-bit BMP byte stream.
module bmp_gray_writer
  import bmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 720,
  parameter int unsigned HEIGHT = 720
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              frame_done_o,
  bmp_gray_writer_if.master bus
);

  localparam int unsigned ColW = $clog2(WIDTH + 1);
  localparam int unsigned RowW = $clog2(HEIGHT + 1);
  localparam int unsigned Pad  = row_pad(WIDTH);

  localparam logic [1:0]      PadLast = (Pad == 0) ? 2'd0 : 2'(Pad - 1);
  localparam logic [5:0]      HdrLast = 6'(HEADER_SIZE - 1);
  localparam logic [ColW-1:0] ColEnd  = ColW'(WIDTH);
  localparam logic [RowW-1:0] RowEnd  = RowW'(HEIGHT);

  bmp_state_t      state_q, state_d;
  logic [5:0]      hidx_q, hidx_d;
  logic [1:0]      sub_q, sub_d;
  logic [ColW-1:0] col_q, col_d, col_inc;
  logic [RowW-1:0] row_q, row_d, row_inc;
  logic [1:0]      padcnt_q, padcnt_d;
  logic [7:0]      pix_q, pix_d;
  logic            rd_en_q, rd_en_d;
  logic            frame_done_q, frame_done_d;
  logic            row_done;
  logic [7:0]      hdr_byte;

  bmp_header_rom #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_header_rom (
    .hidx_i(hidx_q),
    .byte_o(hdr_byte)
  );

  // Next-state logic; out_full freezes every counter so the same byte is re-presented.
  always_comb begin
    state_d      = state_q;
    hidx_d       = hidx_q;
    sub_d        = sub_q;
    col_d        = col_q;
    row_d        = row_q;
    padcnt_d     = padcnt_q;
    pix_d        = pix_q;
    rd_en_d      = 1'b0;
    frame_done_d = 1'b0;
    row_done     = 1'b0;
    col_inc      = col_q + 1'b1;
    row_inc      = row_q + 1'b1;

    case (state_q)
      StIdle: begin
        // The frame_done cycle still belongs to the finished frame.
        if (start_i && !frame_done_q) begin
          state_d  = StHdr;
          hidx_d   = '0;
          sub_d    = '0;
          col_d    = '0;
          row_d    = '0;
          padcnt_d = '0;
        end
      end
      StHdr: begin
        if (!bus.out_full) begin
          if (hidx_q == HdrLast) begin
            hidx_d  = '0;
            state_d = StFetch;
            rd_en_d = !bus.in_empty;
          end else begin
            hidx_d = hidx_q + 6'd1;
          end
        end
      end
      StFetch: begin
        // rd_en is registered from the empty flag seen one cycle earlier; only this
        // block drains the FIFO, so a non-empty FIFO cannot turn empty in between.
        if (rd_en_q) begin
          state_d = StCapt;
        end else begin
          rd_en_d = !bus.in_empty;
        end
      end
      StCapt: begin
        pix_d   = bus.in_dout;
        sub_d   = '0;
        state_d = StPix;
      end
      StPix: begin
        if (!bus.out_full) begin
          if (sub_q == 2'd2) begin
            sub_d = '0;
            if (col_inc == ColEnd) begin
              col_d = '0;
              if (Pad == 0) begin
                row_done = 1'b1;
              end else begin
                padcnt_d = '0;
                state_d  = StPad;
              end
            end else begin
              col_d   = col_inc;
              state_d = StFetch;
              rd_en_d = !bus.in_empty;
            end
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      StPad: begin
        if (!bus.out_full) begin
          if (padcnt_q == PadLast) begin
            padcnt_d = '0;
            row_done = 1'b1;
          end else begin
            padcnt_d = padcnt_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (row_done) begin
      if (row_inc == RowEnd) begin
        row_d        = '0;
        frame_done_d = 1'b1;
        state_d      = StIdle;
      end else begin
        row_d   = row_inc;
        state_d = StFetch;
        rd_en_d = !bus.in_empty;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      hidx_q       <= '0;
      sub_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      padcnt_q     <= '0;
      pix_q        <= '0;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hidx_q       <= hidx_d;
      sub_q        <= sub_d;
      col_q        <= col_d;
      row_q        <= row_d;
      padcnt_q     <= padcnt_d;
      pix_q        <= pix_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Byte output: write strobe gated by out_full, data decoded from state and counters.
  always_comb begin
    bus.out_wr_en = 1'b0;
    bus.out_din   = 8'h00;
    case (state_q)
      StHdr: begin
        bus.out_wr_en = !bus.out_full;
        bus.out_din   = hdr_byte;
      end
      StPix: begin
        bus.out_wr_en = !bus.out_full;
        bus.out_din   = pix_q;
      end
      StPad: begin
        bus.out_wr_en = !bus.out_full;
        bus.out_din   = 8'h00;
      end
      default: begin
        bus.out_wr_en = 1'b0;
        bus.out_din   = 8'h00;
      end
    endcase
  end

  assign bus.in_rd_en = rd_en_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_bmp_gray_writer.sv
// Directed bench: a 720x720 writer for header/latency/reset, a 5x2 writer for padding,
// backpressure and start filtering.
`timescale 1ns/1ps
module tb_bmp_gray_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic b_start, s_start;
  logic b_busy, b_fd, s_busy, s_fd;

  bmp_gray_writer_if b_if ();
  bmp_gray_writer_if s_if ();

  bmp_gray_writer #(.WIDTH(720), .HEIGHT(720)) u_big (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .busy_o(b_busy),
    .frame_done_o(b_fd), .bus(b_if)
  );

  bmp_gray_writer #(.WIDTH(5), .HEIGHT(2)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .busy_o(s_busy),
    .frame_done_o(s_fd), .bus(s_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Big instance: never-empty source, first two pixels 0x12 and 0x34.
  int         b_rp = 0;
  int         b_wcnt = 0;
  logic [7:0] b_log [0:63];

  // Small instance: preloaded source and logged sink.
  logic [7:0] s_mem [0:255];
  int         s_wp = 0;
  int         s_rp = 0;
  logic [7:0] s_log [0:2047];
  int         s_wcnt = 0;
  int         s_rdcnt = 0;
  int         s_fdcnt = 0;
  int         s_last_wr = 0;
  int         s_fd_cyc = 0;
  int         s_viol = 0;
  logic [7:0] s_exp [0:85];
  logic [7:0] s_px [0:9];

  assign b_if.in_empty = 1'b0;
  assign s_if.in_empty = (s_rp == s_wp);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b_if.in_rd_en) begin
      b_if.in_dout <= (b_rp == 0) ? 8'h12 : (b_rp == 1) ? 8'h34 : 8'(b_rp);
      b_rp <= b_rp + 1;
    end
    if (b_if.out_wr_en) begin
      if (b_wcnt < 64) b_log[b_wcnt] <= b_if.out_din;
      b_wcnt <= b_wcnt + 1;
    end
    if (s_if.in_rd_en) begin
      if (s_rp == s_wp) s_viol <= s_viol + 1;
      s_if.in_dout <= s_mem[s_rp % 256];
      s_rp <= s_rp + 1;
      s_rdcnt <= s_rdcnt + 1;
    end
    if (s_if.out_wr_en) begin
      if (s_if.out_full) s_viol <= s_viol + 1;
      s_log[s_wcnt % 2048] <= s_if.out_din;
      s_wcnt <= s_wcnt + 1;
      s_last_wr <= cyc;
    end
    if (s_fd) begin
      s_fdcnt <= s_fdcnt + 1;
      s_fd_cyc <= cyc;
    end
  end

  function automatic void put32(input int at, input int unsigned v);
    for (int k = 0; k < 4; k++) s_exp[at + k] = 8'(v >> (8 * k));
  endfunction

  // Expected 5x2 stream: hand-derived header (rowbytes 16, image 32, file 86) + pixels.
  function automatic void build_exp();
    s_exp[0] = 8'h42;
    s_exp[1] = 8'h4D;
    put32(2, 86);
    put32(6, 0);
    put32(10, 54);
    put32(14, 40);
    put32(18, 5);
    put32(22, 2);
    put32(26, 32'h0018_0001);
    put32(30, 0);
    put32(34, 32);
    put32(38, 2835);
    put32(42, 2835);
    put32(46, 0);
    put32(50, 0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 5; c++) begin
        for (int j = 0; j < 3; j++) s_exp[54 + r * 16 + c * 3 + j] = s_px[r * 5 + c];
      end
      s_exp[54 + r * 16 + 15] = 8'h00;
    end
  endfunction

  function automatic int count_mism(input int base);
    int m = 0;
    for (int k = 0; k < 86; k++) begin
      if (s_log[(base + k) % 2048] !== s_exp[k]) m++;
    end
    return m;
  endfunction

  task automatic load_pixels(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      s_mem[s_wp % 256] = s_px[k];
      s_wp = s_wp + 1;
    end
  endtask

  task automatic pulse_s_start();
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic wait_s_frame(input int fd0, input int bound);
    int k = 0;
    while (s_fdcnt == fd0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (s_fdcnt == fd0) begin
      errors++;
      $display("FAIL frame_done_timeout: got no pulse within %0d cycles, required one", bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks += 6;
    if (b_busy !== 1'b0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b/%b required 0/0", b_busy, s_busy);
    end
    if (b_fd !== 1'b0 || s_fd !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done: got %b/%b required 0/0", b_fd, s_fd);
    end
    if (b_if.in_rd_en !== 1'b0 || s_if.in_rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_rd_en: got %b/%b required 0/0", b_if.in_rd_en, s_if.in_rd_en);
    end
    if (b_if.out_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_wr_en_big: got %b required 0", b_if.out_wr_en);
    end
    if (s_if.out_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_wr_en_small: got %b required 0", s_if.out_wr_en);
    end
    if (b_if.out_din !== 8'h00 || s_if.out_din !== 8'h00) begin
      errors++; $display("FAIL reset_din: got %h/%h required 00/00", b_if.out_din, s_if.out_din);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_header();
    int idx [21] = '{0, 1, 2, 3, 4, 5, 18, 19, 20, 21, 34, 35, 36, 37, 28,
                     54, 55, 56, 57, 58, 59};
    logic [7:0] val [21] = '{8'h42, 8'h4D, 8'h36, 8'hBB, 8'h17, 8'h00, 8'hD0, 8'h02,
                             8'h00, 8'h00, 8'h00, 8'hBB, 8'h17, 8'h00, 8'h18,
                             8'h12, 8'h12, 8'h12, 8'h34, 8'h34, 8'h34};
    int k = 0;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    checks++;
    if (b_if.out_wr_en !== 1'b1 || b_if.out_din !== 8'h42 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: got wr=%b din=%h busy=%b required wr=1 din=42 busy=1",
               b_if.out_wr_en, b_if.out_din, b_busy);
    end
    while (b_wcnt < 60 && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (b_wcnt < 60) begin
      errors++; $display("FAIL header_timeout: got %0d writes required >= 60", b_wcnt);
    end
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (b_log[idx[i]] !== val[i]) begin
        errors++;
        $display("FAIL header_byte_%0d: got %h required %h", idx[i], b_log[idx[i]], val[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_padding();
    int base, fd0;
    for (int k = 0; k < 10; k++) s_px[k] = 8'hA0 + 8'(k);
    build_exp();
    load_pixels(0, 10);
    base = s_wcnt;
    fd0 = s_fdcnt;
    pulse_s_start();
    wait_s_frame(fd0, 1000);
    repeat (5) @(negedge clk);
    checks += 8;
    if (s_wcnt - base != 86) begin
      errors++; $display("FAIL pad_total_writes: got %0d required 86", s_wcnt - base);
    end
    if (s_fdcnt - fd0 != 1) begin
      errors++; $display("FAIL pad_frame_done_count: got %0d required 1", s_fdcnt - fd0);
    end
    if (s_fd_cyc != s_last_wr + 1) begin
      errors++; $display("FAIL pad_frame_done_timing: got cycle %0d required %0d",
                         s_fd_cyc, s_last_wr + 1);
    end
    if (s_busy !== 1'b0) begin
      errors++; $display("FAIL pad_busy_after: got %b required 0", s_busy);
    end
    if (s_log[(base + 2) % 2048] !== 8'h56) begin
      errors++; $display("FAIL pad_file_size: got %h required 56", s_log[(base + 2) % 2048]);
    end
    if (s_log[(base + 69) % 2048] !== 8'h00 || s_log[(base + 68) % 2048] !== 8'hA4) begin
      errors++; $display("FAIL pad_row0_end: got %h %h required a4 00",
                         s_log[(base + 68) % 2048], s_log[(base + 69) % 2048]);
    end
    if (s_log[(base + 85) % 2048] !== 8'h00) begin
      errors++; $display("FAIL pad_row1_end: got %h required 00", s_log[(base + 85) % 2048]);
    end
    if (count_mism(base) != 0) begin
      errors++; $display("FAIL pad_stream: got %0d mismatched bytes required 0", count_mism(base));
    end
  endtask

  task automatic test_backpressure();
    int base, fd0, w0, r0, stall_wr, k;
    for (int i = 0; i < 10; i++) s_px[i] = 8'h30 + 8'(3 * i);
    build_exp();
    load_pixels(0, 3);
    base = s_wcnt;
    fd0 = s_fdcnt;
    pulse_s_start();
    k = 0;
    while (s_wcnt - base != 55 && k < 300) begin
      @(negedge clk);
      k++;
    end
    // Now presenting pixel 0, sub 1.
    s_if.out_full = 1'b1;
    w0 = s_wcnt;
    stall_wr = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_if.out_wr_en) stall_wr++;
    end
    checks += 2;
    if (stall_wr != 0 || s_wcnt != w0) begin
      errors++; $display("FAIL full_stall_writes: got %0d/%0d required 0/0", stall_wr, s_wcnt - w0);
    end
    if (s_if.out_din !== 8'h30) begin
      errors++; $display("FAIL full_stall_din: got %h required 30", s_if.out_din);
    end
    s_if.out_full = 1'b0;
    #1;
    checks++;
    if (s_if.out_wr_en !== 1'b1 || s_if.out_din !== 8'h30) begin
      errors++; $display("FAIL full_release_repeat: got wr=%b din=%h required wr=1 din=30",
                         s_if.out_wr_en, s_if.out_din);
    end
    k = 0;
    while (s_wcnt - base != 63 && k < 300) begin
      @(negedge clk);
      k++;
    end
    r0 = s_rdcnt;
    repeat (20) @(negedge clk);
    checks += 2;
    if (s_rdcnt != r0) begin
      errors++; $display("FAIL empty_stall_rd_en: got %0d reads required 0", s_rdcnt - r0);
    end
    if (s_busy !== 1'b1 || s_wcnt - base != 63) begin
      errors++; $display("FAIL empty_stall_hold: got busy=%b writes=%0d required busy=1 writes=63",
                         s_busy, s_wcnt - base);
    end
    load_pixels(3, 7);
    wait_s_frame(fd0, 1000);
    repeat (3) @(negedge clk);
    checks += 3;
    if (s_wcnt - base != 86) begin
      errors++; $display("FAIL bp_total_writes: got %0d required 86", s_wcnt - base);
    end
    if (count_mism(base) != 0) begin
      errors++; $display("FAIL bp_stream: got %0d mismatched bytes required 0", count_mism(base));
    end
    if (s_viol != 0) begin
      errors++; $display("FAIL bp_strobe_rules: got %0d violations required 0", s_viol);
    end
  endtask

  task automatic test_start_during_hdr();
    int base, fd0, k;
    for (int i = 0; i < 10; i++) s_px[i] = 8'hF0 - 8'(i);
    build_exp();
    load_pixels(0, 10);
    base = s_wcnt;
    fd0 = s_fdcnt;
    pulse_s_start();
    repeat (10) @(negedge clk);
    pulse_s_start();
    k = 0;
    while (s_fd !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (s_fd !== 1'b1 || s_busy !== 1'b0) begin
      errors++; $display("FAIL hdr_start_done_cycle: got fd=%b busy=%b required fd=1 busy=0",
                         s_fd, s_busy);
    end
    // start coincident with the frame_done pulse must be ignored.
    s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (s_busy !== 1'b0) begin
      errors++; $display("FAIL start_on_done_ignored: got busy=%b required 0", s_busy);
    end
    if (s_wcnt - base != 86) begin
      errors++; $display("FAIL hdr_start_writes: got %0d required 86", s_wcnt - base);
    end
    if (s_fdcnt - fd0 != 1) begin
      errors++; $display("FAIL hdr_start_frame_done: got %0d required 1", s_fdcnt - fd0);
    end
    if (count_mism(base) != 0) begin
      errors++; $display("FAIL hdr_start_stream: got %0d mismatched bytes required 0",
                         count_mism(base));
    end
  endtask

  task automatic test_reset_mid_pix();
    int base, w0, k;
    base = b_wcnt;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    k = 0;
    while (b_wcnt - base != 54 + 3 * 2160 + 1 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (b_wcnt - base != 54 + 3 * 2160 + 1 || b_if.out_wr_en !== 1'b1) begin
      errors++; $display("FAIL row3_reach: got %0d writes wr=%b required %0d wr=1",
                         b_wcnt - base, b_if.out_wr_en, 54 + 3 * 2160 + 1);
    end
    rst_n = 1'b0;
    #1;
    w0 = b_wcnt;
    checks++;
    if (b_if.out_wr_en !== 1'b0 || b_if.in_rd_en !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_strobes: got wr=%b rd=%b busy=%b required 0/0/0",
                         b_if.out_wr_en, b_if.in_rd_en, b_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b_wcnt != w0 || b_if.out_wr_en !== 1'b0 || b_fd !== 1'b0) begin
      errors++; $display("FAIL mid_reset_quiet: got writes=%0d fd=%b required 0 writes fd=0",
                         b_wcnt - w0, b_fd);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    checks++;
    if (b_if.out_wr_en !== 1'b1 || b_if.out_din !== 8'h42) begin
      errors++; $display("FAIL restart_first_byte: got wr=%b din=%h required wr=1 din=42",
                         b_if.out_wr_en, b_if.out_din);
    end
    do_reset();
  endtask

  initial begin
    b_start = 1'b0;
    s_start = 1'b0;
    b_if.out_full = 1'b0;
    s_if.out_full = 1'b0;
    test_reset();
    test_header();
    test_padding();
    test_backpressure();
    test_start_during_hdr();
    test_reset_mid_pix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
